// File: rtl/p6_defs.sv
// p6_defs: shared widths, reset PC and fetch FSM state encoding for the p6 core.
package p6_defs;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/p6_fetch_unit.sv
// p6_fetch_unit: owns the PC, drives the RAM address and hands fetched words to the decoder.
// Ports: clk/reset_n (async active-low); en enables new fetches; branch_valid/branch_target redirect;
// mem_address/mem_data talk to the 1-cycle-latency RAM; instr/instr_pc/instr_valid/instr_ready form
// the decoder handshake; pc exposes the current program counter.
module p6_fetch_unit
  import p6_defs::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc
);
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0] pc_n, instr_pc_n;
  logic [DATA_W-1:0] instr_n;
  logic valid_n;
  assign mem_address = pc;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= valid_n;
    end
  end
  // A branch overrides everything: it discards a word arriving in WAIT and
  // flushes a held instruction even when the decoder accepts it that cycle.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    valid_n    = instr_valid;
    if (branch_valid) begin
      pc_n    = branch_target;
      valid_n = 1'b0;
      state_n = en ? ISSUE : IDLE;
    end else begin
      case (state)
        IDLE:  state_n = en ? ISSUE : IDLE;
        ISSUE: state_n = WAIT;
        WAIT: begin
          instr_n    = mem_data;
          instr_pc_n = pc;
          valid_n    = 1'b1;
          pc_n       = pc + 1'b1;
          state_n    = HOLD;
        end
        HOLD: begin
          valid_n = instr_ready ? 1'b0 : instr_valid;
          state_n = instr_ready ? (en ? ISSUE : IDLE) : HOLD;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_p6_fetch_unit.sv
// tb_p6_fetch_unit: directed and randomized bench with a queue scoreboard for p6_fetch_unit.
module tb_p6_fetch_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic branch_valid = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic [7:0] mem_address;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic [7:0] instr_pc;
  logic instr_valid;
  logic instr_ready = 1'b0;
  logic [7:0] pc;
  logic [15:0] mem [256];
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  p6_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .en(en), .branch_valid(branch_valid),
    .branch_target(branch_target), .mem_address(mem_address), .mem_data(mem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_address];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: the delivered stream must be mem[a], mem[a+1], ...
  // where a restarts at RESET_PC after reset and at the target after a branch.
  initial begin
    logic p_v, p_r, p_b, p_rst;
    logic [7:0] p_t, p_ipc, p_pc, a;
    logic [15:0] p_instr;
    exp_q.push_back(8'h00);
    forever begin
      @(posedge clk);
      p_v = instr_valid; p_r = instr_ready; p_b = branch_valid; p_t = branch_target;
      p_instr = instr; p_ipc = instr_pc; p_pc = pc; p_rst = reset_n;
      #1;
      if (!p_rst || !reset_n) begin
        exp_q.delete();
        exp_q.push_back(8'h00);
        continue;
      end
      chk("mem_address_eq_pc", {24'd0, mem_address}, {24'd0, pc});
      if (p_b) begin
        chk("branch_flush_valid", {31'd0, instr_valid}, 32'd0);
        chk("branch_pc", {24'd0, pc}, {24'd0, p_t});
        exp_q.delete();
        exp_q.push_back(p_t);
      end else if (p_v && p_r) begin
        chk("handshake_clears_valid", {31'd0, instr_valid}, 32'd0);
      end else if (p_v) begin
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_instr", {16'd0, instr}, {16'd0, p_instr});
        chk("hold_instr_pc", {24'd0, instr_pc}, {24'd0, p_ipc});
        chk("hold_pc", {24'd0, pc}, {24'd0, p_pc});
      end
      if (instr_valid && !p_v) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          a = exp_q.pop_front();
          chk("sb_instr_pc", {24'd0, instr_pc}, {24'd0, a});
          chk("sb_instr", {16'd0, instr}, {16'd0, mem[a]});
          exp_q.push_back(a + 8'd1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s_instr;
    logic [7:0] s_ipc, s_pc;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hA001;
    // reset values
    tick(2);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_instr_pc", {24'd0, instr_pc}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_mem_address", {24'd0, mem_address}, 32'd0);
    reset_n = 1'b1;
    // first fetch and the one after it
    tick(1);
    en = 1'b1; instr_ready = 1'b1;
    tick(3);
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_instr", {16'd0, instr}, 32'hA001);
    chk("first_instr_pc", {24'd0, instr_pc}, 32'd0);
    chk("first_pc", {24'd0, pc}, 32'd1);
    tick(3);
    chk("second_valid", {31'd0, instr_valid}, 32'd1);
    chk("second_instr_pc", {24'd0, instr_pc}, 32'd1);
    chk("second_instr", {16'd0, instr}, {16'd0, mem[1]});
    chk("second_pc", {24'd0, pc}, 32'd2);
    // backpressure for 5 cycles
    instr_ready = 1'b0;
    s_instr = instr; s_ipc = instr_pc; s_pc = pc;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_instr", {16'd0, instr}, {16'd0, s_instr});
      chk("bp_instr_pc", {24'd0, instr_pc}, {24'd0, s_ipc});
      chk("bp_mem_address", {24'd0, mem_address}, {24'd0, s_pc});
    end
    instr_ready = 1'b1;
    tick(1);
    chk("bp_release_valid", {31'd0, instr_valid}, 32'd0);
    instr_ready = 1'b0;
    tick(2);
    chk("bp_next_instr_pc", {24'd0, instr_pc}, 32'd2);
    chk("bp_next_pc", {24'd0, pc}, 32'd3);
    tick(2);
    chk("bp_single_fetch_pc", {24'd0, pc}, 32'd3);
    // wrap from 0xFF to 0x00
    mem[8'hFF] = 16'h1234; mem[0] = 16'h5678;
    branch_valid = 1'b1; branch_target = 8'hFF;
    tick(1);
    branch_valid = 1'b0; instr_ready = 1'b1;
    chk("wrap_branch_pc", {24'd0, pc}, 32'hFF);
    tick(2);
    chk("wrap_instr_a", {16'd0, instr}, 32'h1234);
    chk("wrap_instr_pc_a", {24'd0, instr_pc}, 32'hFF);
    chk("wrap_pc", {24'd0, pc}, 32'h00);
    tick(3);
    chk("wrap_instr_b", {16'd0, instr}, 32'h5678);
    chk("wrap_instr_pc_b", {24'd0, instr_pc}, 32'h00);
    // branch while in WAIT
    instr_ready = 1'b0;
    branch_valid = 1'b1; branch_target = 8'h10;
    tick(1);
    branch_valid = 1'b0;
    tick(1);
    chk("wait_pc", {24'd0, pc}, 32'h10);
    branch_valid = 1'b1; branch_target = 8'h40;
    tick(1);
    branch_valid = 1'b0; instr_ready = 1'b1;
    chk("wait_branch_valid", {31'd0, instr_valid}, 32'd0);
    tick(1);
    chk("wait_branch_no_stale", {31'd0, instr_valid}, 32'd0);
    tick(1);
    chk("wait_branch_instr_pc", {24'd0, instr_pc}, 32'h40);
    chk("wait_branch_instr", {16'd0, instr}, {16'd0, mem[8'h40]});
    // branch coincident with handshake
    branch_valid = 1'b1; branch_target = 8'h80;
    tick(1);
    branch_valid = 1'b0;
    chk("hs_branch_valid", {31'd0, instr_valid}, 32'd0);
    chk("hs_branch_pc", {24'd0, pc}, 32'h80);
    tick(2);
    chk("hs_branch_instr_pc", {24'd0, instr_pc}, 32'h80);
    // async reset between edges while in WAIT
    tick(2);
    chk("pre_reset_pc", {24'd0, pc}, 32'h81);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_rst_pc", {24'd0, pc}, 32'd0);
    chk("async_rst_instr", {16'd0, instr}, 32'd0);
    chk("async_rst_instr_pc", {24'd0, instr_pc}, 32'd0);
    chk("async_rst_mem_address", {24'd0, mem_address}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("restart_valid", {31'd0, instr_valid}, 32'd1);
    chk("restart_instr_pc", {24'd0, instr_pc}, 32'd0);
    chk("restart_instr", {16'd0, instr}, 32'h5678);
    // randomized traffic, checked by the scoreboard monitor
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      branch_valid = ($urandom_range(0, 11) == 0);
      branch_target = 8'($urandom);
      tick(1);
    end
    branch_valid = 1'b0;
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/p6_fetch_unit.md
Name: p6_fetch_unit

Overview:
Instruction fetch stage directly upstream of the 256x16 single-port synchronous RAM (registered read, 1-cycle latency). It owns the program counter and drives the RAM address. It captures the returned word into an instruction register and presents it to the decoder with a valid/ready handshake. A redirect input supports taken branches, flushing any in-flight fetch.

Parameters:
ADDR_W, 8, PC and RAM address width (256 words)
DATA_W, 16, instruction/RAM word width
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
en  input  1  run enable; 0 = no new fetch issued
branch_valid  input  1  taken-branch redirect strobe, one cycle
branch_target  input  ADDR_W  redirect PC, sampled when branch_valid=1
mem_address  output  ADDR_W  RAM address; always equals pc register
mem_data  input  DATA_W  RAM data_out (registered read of previous-edge address)
instr  output  DATA_W  fetched instruction register
instr_pc  output  ADDR_W  address the current instr was fetched from
instr_valid  output  1  instr holds an unconsumed instruction
instr_ready  input  1  decoder accepts instr when instr_valid & instr_ready
pc  output  ADDR_W  current PC (debug/branch-offset base)

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, state=IDLE, instr=0, instr_pc=0, instr_valid=0. mem_address=RESET_PC.
- RAM fetch port has we tied low at top level. This block never writes.
- mem_address is driven combinationally from the pc register only, so it is glitch-free and stable for the whole cycle.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: instr_valid=0. Goes to ISSUE when en=1.
  - ISSUE: pc is on mem_address. The RAM captures it at the next edge. Always goes to WAIT.
  - WAIT: mem_data = mem[pc]. At the edge: instr<=mem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1, go to HOLD.
  - HOLD: instr_valid=1, instr and instr_pc held stable. On instr_ready=1 at the edge: instr_valid<=0, then go to ISSUE if en=1, else IDLE.
- Latency: 2 cycles from ISSUE entry to instr_valid=1. Peak throughput is 1 instruction per 3 cycles.
- PC increments modulo 2^ADDR_W: 8'hFF+1 = 8'h00, with no flag.
- Branch (branch_valid=1 at an edge) has the highest priority in every state except reset:
  - pc<=branch_target and instr_valid<=0 (the held instruction is flushed even if instr_ready=1 that same cycle; the decoder must not count it as consumed).
  - Any WAIT data is discarded.
  - Next state is ISSUE if en=1, else IDLE.
- en deasserted mid-fetch: an ISSUE/WAIT in progress completes into HOLD. After the handshake the FSM goes to IDLE. en is never an abort.
- instr_ready while instr_valid=0 has no effect.
- Reset asserted mid-operation: immediate return to reset values. The RAM read in flight is ignored.

Decomposition:
- Shared package/header p6_defs: ADDR_W, DATA_W, RESET_PC and FSM state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, HOLD=2'd3), also used by the decoder and top level.
- No sub-module needed; PC register, FSM and IR live in one module. The top level instantiates p6_fetch_unit next to p6_ram.

Test Plan:
- Reset then en=1: RAM word 0 = 16'hA001, instr_ready=1 held. Required: instr=16'hA001, instr_pc=0, instr_valid=1 two cycles after ISSUE. Next instr is from address 1, pc=2 after the second capture.
- Backpressure: instr_ready=0 for 5 cycles in HOLD. Required: instr, instr_pc and instr_valid stable, pc unchanged, mem_address constant. Raising ready then produces one handshake and exactly one new fetch.
- Wrap: branch to 8'hFF, word FF=16'h1234, word 0=16'h5678. Required: instr sequence 16'h1234 then 16'h5678 with instr_pc FF then 00.
- Branch during WAIT: pc=8'h10, branch_valid with target 8'h40. Required: word 0x10 never reaches instr_valid=1. The next valid instr has instr_pc=8'h40.
- Branch coincident with handshake in HOLD: required instr_valid=0 the next cycle and the next fetch from branch_target, not pc+1.
- Async reset asserted mid-WAIT, between clock edges: required outputs return to reset values immediately, without waiting for an edge. After release with en=1 the fetch restarts at RESET_PC.
